// File: rtl/fmul_rsh_round_pipe_if.sv
// rtl/fmul_rsh_round_pipe_if.sv - input/output handshake bundle for the subnormal rounding pipe
interface fmul_rsh_round_pipe_if #(
  parameter int SIG_W = 53,
  parameter int RSH_W = 6,
  parameter int TAG_W = 4
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [2*SIG_W-1:0]   sig_mul_i;
  logic [RSH_W-1:0]     rsh_num_i;
  logic [2:0]           rm_i;
  logic                 sign_i;
  logic [TAG_W-1:0]     tag_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [SIG_W-1:0]     sig_o;
  logic                 inexact_o;
  logic                 uf_o;
  logic [TAG_W-1:0]     tag_o;

  modport master (
    output in_valid_i, sig_mul_i, rsh_num_i, rm_i, sign_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, sig_o, inexact_o, uf_o, tag_o
  );

  modport slave (
    input  in_valid_i, sig_mul_i, rsh_num_i, rm_i, sign_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, sig_o, inexact_o, uf_o, tag_o
  );
endinterface

// File: rtl/fmul_rsh_round_pipe.sv
// rtl/fmul_rsh_round_pipe.sv - two-stage right-shift rounding unit for the fmul subnormal path
module fmul_rsh_round_pipe #(
  parameter int SIG_W = 53,
  parameter int RSH_W = 6,
  parameter int TAG_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush_i,
  fmul_rsh_round_pipe_if.slave bus
);
  localparam int PW = 2 * SIG_W;

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic l, input logic g, input logic s);
    logic inc;
    case (rm)
      3'd0:    inc = g & (l | s);
      3'd2:    inc = sign & (g | s);
      3'd3:    inc = ~sign & (g | s);
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  logic             s1_valid;
  logic             out_valid;
  logic             s1_adv;
  logic             s2_adv;

  assign s2_adv         = ~out_valid | bus.out_ready_i;
  assign s1_adv         = ~s1_valid | s2_adv;
  assign bus.in_ready_o = s1_adv | flush_i;

  // Stage-1 mask generation
  logic [RSH_W-1:0] r;
  logic [PW-1:0]    sh;
  logic [SIG_W-1:0] trunc_c;
  logic             l_c, g_c, s_c, g_uf_c, s_uf_c, all1_c;

  assign r       = (bus.rsh_num_i == '0) ? RSH_W'(1) : bus.rsh_num_i;
  assign sh      = bus.sig_mul_i >> r;
  assign l_c     = sh[SIG_W-1];
  assign g_c     = sh[SIG_W-2];
  assign g_uf_c  = sh[SIG_W-3];
  assign trunc_c = SIG_W'(sh >> (SIG_W - 1));
  assign all1_c  = (r == RSH_W'(1)) && (&bus.sig_mul_i[PW-2:SIG_W-1]);

  // Sticky bits: OR of everything below the guard position (and one lower for the uf check)
  always_comb begin
    s_c    = 1'b0;
    s_uf_c = 1'b0;
    for (int i = 0; i < PW; i++) begin
      if (i < SIG_W - 2 + int'(r)) s_c    = s_c | bus.sig_mul_i[i];
      if (i < SIG_W - 3 + int'(r)) s_uf_c = s_uf_c | bus.sig_mul_i[i];
    end
  end

  logic [SIG_W-1:0] s1_trunc;
  logic             s1_l, s1_g, s1_s, s1_g_uf, s1_s_uf, s1_all1, s1_sign;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_trunc <= '0;
      s1_l     <= 1'b0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_g_uf  <= 1'b0;
      s1_s_uf  <= 1'b0;
      s1_all1  <= 1'b0;
      s1_rm    <= '0;
      s1_sign  <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (flush_i)     s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= bus.in_valid_i;
      if (!flush_i && s1_adv && bus.in_valid_i) begin
        s1_trunc <= trunc_c;
        s1_l     <= l_c;
        s1_g     <= g_c;
        s1_s     <= s_c;
        s1_g_uf  <= g_uf_c;
        s1_s_uf  <= s_uf_c;
        s1_all1  <= all1_c;
        s1_rm    <= bus.rm_i;
        s1_sign  <= bus.sign_i;
        s1_tag   <= bus.tag_i;
      end
    end
  end

  // L_uf sits at the same bit position as G, so s1_g doubles as it
  logic             inc, inc_uf, inexact_c, uf_c;
  logic [SIG_W-1:0] sig_c;

  assign inc       = round_inc(s1_rm, s1_sign, s1_l, s1_g, s1_s);
  assign inc_uf    = round_inc(s1_rm, s1_sign, s1_g, s1_g_uf, s1_s_uf);
  assign sig_c     = s1_trunc + {{(SIG_W-1){1'b0}}, inc};
  assign inexact_c = s1_g | s1_s;
  assign uf_c      = inexact_c & ~(s1_all1 & inc_uf);

  logic [SIG_W-1:0] sig_q;
  logic             inexact_q, uf_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sig_q     <= '0;
      inexact_q <= 1'b0;
      uf_q      <= 1'b0;
      tag_q     <= '0;
    end else begin
      if (flush_i)     out_valid <= 1'b0;
      else if (s2_adv) out_valid <= s1_valid;
      if (!flush_i && s2_adv && s1_valid) begin
        sig_q     <= sig_c;
        inexact_q <= inexact_c;
        uf_q      <= uf_c;
        tag_q     <= s1_tag;
      end
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.sig_o       = sig_q;
  assign bus.inexact_o   = inexact_q;
  assign bus.uf_o        = uf_q;
  assign bus.tag_o       = tag_q;
endmodule

// File: tb/tb_fmul_rsh_round_pipe.sv
// tb/tb_fmul_rsh_round_pipe.sv - scoreboard bench for the subnormal rounding pipe (F16 and F64)
module tb_fmul_rsh_round_pipe;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  fmul_rsh_round_pipe_if #(.SIG_W(11), .RSH_W(6), .TAG_W(4)) b11 ();
  fmul_rsh_round_pipe_if #(.SIG_W(53), .RSH_W(6), .TAG_W(4)) b53 ();

  fmul_rsh_round_pipe #(.SIG_W(11), .RSH_W(6), .TAG_W(4)) dut11 (
    .clk(clk), .rst(rst), .flush_i(flush), .bus(b11.slave));
  fmul_rsh_round_pipe #(.SIG_W(53), .RSH_W(6), .TAG_W(4)) dut53 (
    .clk(clk), .rst(rst), .flush_i(flush), .bus(b53.slave));

  typedef struct packed {
    logic [63:0] sig;
    logic        inexact;
    logic        uf;
    logic [3:0]  tag;
  } res_t;

  res_t q11[$];
  res_t q53[$];
  res_t obs53[$];
  res_t pend11, pend53;
  logic acc11, acc53;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [127:0] m, input int pw, input int idx);
    return (idx >= 0 && idx < pw) ? m[idx] : 1'b0;
  endfunction

  function automatic logic rnd(input int rm, input logic sign, input logic l, input logic g, input logic s);
    if (rm == 0) return g && (l || s);
    if (rm == 2) return sign && (g || s);
    if (rm == 3) return !sign && (g || s);
    if (rm == 4) return g;
    return 1'b0;
  endfunction

  function automatic res_t model(input int sw, input logic [127:0] m, input int rsh, input int rm,
                                 input logic sign, input logic [3:0] tag);
    res_t e;
    int pw, r;
    logic l, g, s, lu, gu, su, all1;
    logic [63:0] tr;
    pw = 2 * sw;
    r  = (rsh == 0) ? 1 : rsh;
    l  = bit_at(m, pw, sw - 1 + r);
    g  = bit_at(m, pw, sw - 2 + r);
    lu = bit_at(m, pw, sw - 2 + r);
    gu = bit_at(m, pw, sw - 3 + r);
    s  = 1'b0;
    su = 1'b0;
    for (int i = 0; i <= sw - 3 + r; i++) s  = s  | bit_at(m, pw, i);
    for (int i = 0; i <= sw - 4 + r; i++) su = su | bit_at(m, pw, i);
    tr = '0;
    for (int j = 0; j < sw; j++) tr[j] = bit_at(m, pw, sw - 1 + r + j);
    all1 = (r == 1);
    for (int i = sw - 1; i <= pw - 2; i++) all1 = all1 & m[i];
    e.sig     = (tr + 64'(rnd(rm, sign, l, g, s))) & ((64'd1 << sw) - 64'd1);
    e.inexact = g | s;
    e.uf      = e.inexact & ~(all1 & rnd(rm, sign, lu, gu, su));
    e.tag     = tag;
    return e;
  endfunction

  task automatic set11(input logic [127:0] m, input int rsh, input int rm, input logic sign, input logic [3:0] tag);
    b11.sig_mul_i  = m[21:0];
    b11.rsh_num_i  = 6'(rsh);
    b11.rm_i       = 3'(rm);
    b11.sign_i     = sign;
    b11.tag_i      = tag;
    b11.in_valid_i = 1'b1;
    pend11 = model(11, m, rsh, rm, sign, tag);
  endtask

  task automatic set53(input logic [127:0] m, input int rsh, input int rm, input logic sign, input logic [3:0] tag);
    b53.sig_mul_i  = m[105:0];
    b53.rsh_num_i  = 6'(rsh);
    b53.rm_i       = 3'(rm);
    b53.sign_i     = sign;
    b53.tag_i      = tag;
    b53.in_valid_i = 1'b1;
    pend53 = model(53, m, rsh, rm, sign, tag);
  endtask

  function automatic logic [127:0] rand11();
    logic [127:0] v;
    v = 128'($urandom);
    v[127:21] = '0;
    return v;
  endfunction

  // One clock: sample/score just before the edge, then advance to the next falling edge
  task automatic tick();
    int occ;
    res_t o;
    #1;
    occ = q11.size();
    if (!rst) chk("in_ready", 128'(b11.in_ready_o), 128'(flush || !(occ == 2 && !b11.out_ready_i)));
    acc11 = b11.in_valid_i && b11.in_ready_o && !flush && !rst;
    acc53 = b53.in_valid_i && b53.in_ready_o && !flush && !rst;
    if (b11.out_valid_o && b11.out_ready_i) begin
      o = {64'(b11.sig_o), b11.inexact_o, b11.uf_o, b11.tag_o};
      if (q11.size() == 0) chk("out11_idle", 128'(b11.out_valid_o), 128'(0));
      else chk("res11", 128'(o), 128'(q11.pop_front()));
    end
    if (b53.out_valid_o && b53.out_ready_i) begin
      o = {64'(b53.sig_o), b53.inexact_o, b53.uf_o, b53.tag_o};
      obs53.push_back(o);
      if (q53.size() == 0) chk("out53_idle", 128'(b53.out_valid_o), 128'(0));
      else chk("res53", 128'(o), 128'(q53.pop_front()));
    end
    if (acc11) q11.push_back(pend11);
    if (acc53) q53.push_back(pend53);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] m53a, m53x;
    int k, c;
    rst = 1'b1;
    flush = 1'b0;
    b11.in_valid_i = 1'b0; b11.out_ready_i = 1'b1; b11.sig_mul_i = '0; b11.rsh_num_i = '0;
    b11.rm_i = '0; b11.sign_i = 1'b0; b11.tag_i = '0;
    b53.in_valid_i = 1'b0; b53.out_ready_i = 1'b1; b53.sig_mul_i = '0; b53.rsh_num_i = '0;
    b53.rm_i = '0; b53.sign_i = 1'b0; b53.tag_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset11", 128'({b11.out_valid_o, b11.sig_o, b11.inexact_o, b11.uf_o, b11.tag_o}), 128'(0));
    chk("reset53", 128'({b53.out_valid_o, b53.sig_o, b53.inexact_o, b53.uf_o, b53.tag_o}), 128'(0));
    rst = 1'b0;

    // Directed vectors, back to back
    m53a = {$urandom, $urandom, $urandom, $urandom};
    m53a[127:105] = '0;
    m53x = m53a;
    m53x[52:0] = '0;
    set11(128'h1FFC00, 1, 0, 1'b0, 4'd1);
    set53(m53a, 0, 0, 1'b0, 4'd5);
    tick();
    chk("latency_c1", 128'(b11.out_valid_o), 128'(0));
    set11(128'h1FFE00, 1, 0, 1'b0, 4'd2);
    set53(m53a, 1, 0, 1'b0, 4'd5);
    tick();
    chk("latency_c2", 128'(b11.out_valid_o), 128'(1));
    set11(128'h000001, 14, 3, 1'b0, 4'd3);
    set53(m53x, 1, 0, 1'b1, 4'd6);
    tick();
    set11(128'h000001, 14, 1, 1'b0, 4'd4);
    b53.in_valid_i = 1'b0;
    tick();
    b11.in_valid_i = 1'b0;
    repeat (4) tick();
    if (obs53.size() >= 3) begin
      chk("rsh0_vs_rsh1", 128'(obs53[0]), 128'(obs53[1]));
      chk("exact_flags", 128'({obs53[2].inexact, obs53[2].uf}), 128'(0));
    end else begin
      chk("obs53_count", 128'(obs53.size()), 128'(3));
    end

    // Tagged stream under toggling backpressure
    k = 0;
    c = 0;
    while (k < 8 && c < 200) begin
      b11.out_ready_i = (c % 4 == 0) || (c % 4 == 3);
      set11(rand11(), int'($urandom_range(0, 20)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'(k));
      tick();
      if (acc11) k++;
      c++;
    end
    chk("stream_sent", 128'(k), 128'(8));
    b11.in_valid_i = 1'b0;
    b11.out_ready_i = 1'b1;
    c = 0;
    while (q11.size() > 0 && c < 20) begin
      tick();
      c++;
    end
    chk("stream_drained", 128'(q11.size()), 128'(0));

    // Flush with both stages full
    b11.out_ready_i = 1'b0;
    set11(rand11(), 3, 0, 1'b0, 4'd9);
    tick();
    set11(rand11(), 5, 4, 1'b1, 4'd10);
    tick();
    chk("full_in_ready", 128'(b11.in_ready_o), 128'(0));
    flush = 1'b1;
    set11(rand11(), 2, 0, 1'b0, 4'd11);
    tick();
    flush = 1'b0;
    q11.delete();
    chk("flush_out_valid", 128'(b11.out_valid_o), 128'(0));
    b11.in_valid_i = 1'b0;
    b11.out_ready_i = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-stream
    b11.out_ready_i = 1'b0;
    set11(128'h1FFC00, 1, 0, 1'b0, 4'd12);
    tick();
    set11(128'h1FFE00, 1, 0, 1'b0, 4'd13);
    tick();
    #2 rst = 1'b1;
    #1 chk("rst_async", 128'({b11.out_valid_o, b11.sig_o, b11.inexact_o, b11.uf_o, b11.tag_o}), 128'(0));
    q11.delete();
    b11.in_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    b11.out_ready_i = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", 128'(b11.out_valid_o), 128'(0));
    chk("q53_empty", 128'(q53.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
